// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encoding, default memory timeout and the control-word layout.
// Optional build macro used by the controller: STALL_PERF_CNT_EN.
package pipe_ctrl_pkg;

    // Encoding is visible on the state output, so the values are fixed.
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_WAIT = 2'd2
    } ctrl_state_e;

    localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
    localparam int          TIMER_W             = 8;

    // Pipeline control word. Field order matches the constants below.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_hold;
        logic exmem_flush;
    } ctrl_out_t;

    // Normal advance: everything moves, nothing is squashed.
    localparam ctrl_out_t CTL_NONE     = 6'b110000;
    // Memory stall: front end frozen, back end held in place.
    localparam ctrl_out_t CTL_MEM      = 6'b000010;
    // Mul/div stall: front end frozen, bubble pushed into EX/MEM.
    localparam ctrl_out_t CTL_MDU      = 6'b000001;
    // Taken branch: PC redirects, wrong-path IF and ID are squashed.
    localparam ctrl_out_t CTL_BRANCH   = 6'b101100;
    // Load-use: PC and IF/ID held, one bubble into ID/EX.
    localparam ctrl_out_t CTL_LOAD_USE = 6'b000100;
    // Held in reset: nothing advances, all bubble stages squashed.
    localparam ctrl_out_t CTL_RESET    = 6'b000111;

endpackage

// File: rtl/stall_timer.sv
// Memory-wait timeout counter. A load starts the count at 1 (the first
// wait cycle), each enabled cycle advances it, and expire is high while
// the count equals TIMEOUT.
module stall_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMEOUT[TIMER_W-1:0];

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Next count: load wins over advance; stop at all-ones so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = {{(TIMER_W-1){1'b0}}, 1'b1};
        end else if (enable_i && (cnt_q != {TIMER_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller. Mealy outputs derived from the current
// wait state and this cycle's hazard inputs; state, timeout timer and the
// sticky mem_err flag are registered.
// Build macro STALL_PERF_CNT_EN adds a saturating 32-bit stall_cnt output
// counting cycles out of reset in which the PC is not written.
// Handshake note: mem_req/mem_ready and mdu_start/mdu_done are sampled
// every cycle; a stall lasts exactly as long as req & ~ready (or
// start & ~done) and releases in the same cycle ready/done rises.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        mdu_start,
    input  logic        mdu_done,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_hold,
    output logic        exmem_flush,
    output logic [1:0]  state,
    output logic        mem_err
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic        mem_err_q;
    logic        mem_err_d;
    ctrl_out_t   ctl;
    logic        timer_load;
    logic        timer_en;
    logic        timer_expire;
    logic        memstall;
    logic        mdustall;

    assign memstall = mem_req & ~mem_ready;
    assign mdustall = mdu_start & ~mdu_done;

    stall_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timer_load),
        .enable_i (timer_en),
        .expire_o (timer_expire)
    );

    // Control decode and next-state selection; reset forces the squash word.
    always_comb begin
        state_d    = state_q;
        mem_err_d  = mem_err_q;
        ctl        = CTL_NONE;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Priority: memory > mul/div > branch > load-use.
                if (memstall) begin
                    ctl        = CTL_MEM;
                    state_d    = ST_MEM_WAIT;
                    timer_load = 1'b1;
                end else if (mdustall) begin
                    ctl     = CTL_MDU;
                    state_d = ST_MDU_WAIT;
                end else if (branch_taken) begin
                    ctl = CTL_BRANCH;
                end else if (load_use) begin
                    ctl = CTL_LOAD_USE;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    ctl      = CTL_MEM;
                    timer_en = 1'b1;
                    // Give up on a memory that never answers.
                    if (timer_expire) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_MDU_WAIT: begin
                // A memory stall in MEM overrides the EX bubble with a hold.
                if (memstall) begin
                    ctl = CTL_MEM;
                end else if (mdu_done) begin
                    state_d = ST_RUN;
                end else begin
                    ctl = CTL_MDU;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (!rst_n) begin
            ctl = CTL_RESET;
        end
    end

    // FSM state and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign pc_write    = ctl.pc_write;
    assign ifid_write  = ctl.ifid_write;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign exmem_hold  = ctl.exmem_hold;
    assign exmem_flush = ctl.exmem_flush;
    assign state       = state_q;
    assign mem_err     = mem_err_q;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count PC-stalled cycles, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (!ctl.pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios followed by random hazard
// traffic, compared against a behavioural model of the stall rules.
module tb_pipe_stall_ctrl;

    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use = 1'b0;
    logic branch_taken = 1'b0;
    logic mem_req = 1'b0;
    logic mem_ready = 1'b0;
    logic mdu_start = 1'b0;
    logic mdu_done = 1'b0;
    logic pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, exmem_flush;
    logic [1:0] state;
    logic mem_err;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .mdu_start    (mdu_start),
        .mdu_done     (mdu_done),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_hold   (exmem_hold),
        .exmem_flush  (exmem_flush),
        .state        (state),
        .mem_err      (mem_err)
`ifdef STALL_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which unit we are waiting on, wait cycles elapsed,
    // error flag and stalled-cycle tally.
    int          m_mode = 0;   // 0 running, 1 waiting on memory, 2 waiting on mul/div
    int          m_wait = 0;
    logic        m_err  = 1'b0;
    logic [31:0] m_cnt  = '0;

    // Expected control word {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, exmem_flush}.
    localparam logic [5:0] W_NORMAL = 6'b110000;
    localparam logic [5:0] W_MEM    = 6'b000010;
    localparam logic [5:0] W_MDU    = 6'b000001;
    localparam logic [5:0] W_BRANCH = 6'b101100;
    localparam logic [5:0] W_LU     = 6'b000100;
    localparam logic [5:0] W_RESET  = 6'b000111;

    function automatic logic [5:0] obs_ctl();
        return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, exmem_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] model_ctl(input logic lu, input logic br, input logic mr,
                                             input logic mrdy, input logic ms, input logic md);
        logic mst;
        logic dst;
        mst = mr & ~mrdy;
        dst = ms & ~md;
        if (m_mode == 1) return mrdy ? W_NORMAL : W_MEM;
        if (m_mode == 2) return mst ? W_MEM : (md ? W_NORMAL : W_MDU);
        if (mst) return W_MEM;
        if (dst) return W_MDU;
        if (br) return W_BRANCH;
        if (lu) return W_LU;
        return W_NORMAL;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_wait = 0;
        m_err  = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ":ctl"}, 32'(obs_ctl()), 32'(W_RESET));
        chk({tag, ":state"}, 32'(state), 32'd0);
        chk({tag, ":err"}, 32'(mem_err), 32'd0);
`ifdef STALL_PERF_CNT_EN
        chk({tag, ":cnt"}, stall_cnt, 32'd0);
`endif
    endtask

    // One clock cycle: drive (just after posedge), check at negedge, advance model.
    task automatic cycle(input string tag, input logic lu, input logic br, input logic mr,
                         input logic mrdy, input logic ms, input logic md);
        logic [5:0] e;
        load_use     = lu;
        branch_taken = br;
        mem_req      = mr;
        mem_ready    = mrdy;
        mdu_start    = ms;
        mdu_done     = md;
        @(negedge clk);
        e = model_ctl(lu, br, mr, mrdy, ms, md);
        chk({tag, ":ctl"}, 32'(obs_ctl()), 32'(e));
        chk({tag, ":state"}, 32'(state), 32'(m_mode));
        chk({tag, ":err"}, 32'(mem_err), 32'(m_err));
`ifdef STALL_PERF_CNT_EN
        chk({tag, ":cnt"}, stall_cnt, m_cnt);
`endif
        if (!e[5] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        case (m_mode)
            0: begin
                if (mr && !mrdy) begin
                    m_mode = 1;
                    m_wait = 0;
                end else if (ms && !md) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (mrdy) begin
                    m_mode = 0;
                end else begin
                    m_wait++;
                    if (m_wait >= int'(TMO)) begin
                        m_err  = 1'b1;
                        m_mode = 0;
                    end
                end
            end
            default: begin
                if (!(mr && !mrdy) && md) m_mode = 0;
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset: outputs squash even before any clock edge.
        #3;
        check_reset("por_async");
        @(negedge clk);
        check_reset("por_clocked");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        cycle("idle", 0, 0, 0, 0, 0, 0);

        // Load-use bubble for one cycle only.
        cycle("lu", 1, 0, 0, 0, 0, 0);
        chk("lu_pc_low", 32'(pc_write), 32'd0);
        cycle("lu_after", 0, 0, 0, 0, 0, 0);
        chk("lu_after_pc", 32'(pc_write), 32'd1);

        // Branch beats load-use in the same cycle.
        cycle("br_lu", 1, 1, 0, 0, 0, 0);
        chk("br_lu_idex", 32'(idex_flush), 32'd1);
        cycle("br_only", 0, 1, 0, 0, 0, 0);

        // Memory stall for three cycles, released on the fourth.
        cycle("mem1", 0, 0, 1, 0, 0, 0);
        cycle("mem2", 0, 0, 1, 0, 0, 0);
        chk("mem2_state", 32'(state), 32'd1);
        cycle("mem3", 0, 0, 1, 0, 0, 0);
        chk("mem3_hold", 32'(exmem_hold), 32'd1);
        cycle("mem_rel", 1, 1, 1, 1, 0, 0);
        chk("mem_rel_pc", 32'(pc_write), 32'd1);
        cycle("mem_post", 0, 0, 0, 0, 0, 0);

        // Memory never answers: timeout after TMO wait cycles.
        cycle("tmo_enter", 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < int'(TMO); i++) cycle("tmo_wait", 0, 1, 1, 0, 0, 0);
        cycle("tmo_back", 0, 0, 0, 0, 0, 0);
        chk("tmo_err", 32'(mem_err), 32'd1);
        chk("tmo_state", 32'(state), 32'd0);
        cycle("tmo_sticky", 0, 0, 0, 0, 0, 0);

        // Mul/div for five cycles with a memory stall on the second.
        cycle("mdu1", 0, 0, 0, 0, 1, 0);
        cycle("mdu2", 1, 1, 1, 0, 1, 0);
        chk("mdu2_hold", 32'(exmem_hold), 32'd1);
        cycle("mdu3", 0, 0, 0, 0, 1, 0);
        cycle("mdu4", 1, 0, 0, 0, 1, 0);
        cycle("mdu5", 0, 1, 0, 0, 1, 0);
        cycle("mdu_rel", 0, 0, 0, 0, 1, 1);
        chk("mdu_rel_pc", 32'(pc_write), 32'd1);
        cycle("mdu_post", 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a mul/div wait.
        cycle("rst_mdu1", 0, 0, 0, 0, 1, 0);
        mdu_start = 1'b1;
        mdu_done  = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid_async");
        model_reset();
        @(negedge clk);
        check_reset("rst_mid_clocked");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("rst_after", 0, 0, 0, 0, 0, 0);

        // Random hazard traffic.
        for (int i = 0; i < 600; i++) begin
            cycle("rand",
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
